// File: rtl/link_watchdog.sv
// Command-link watchdog: trips safe_stop when host writes stop for longer than
// a programmable millisecond timeout, and reports trips/status via readback.
module link_watchdog #(
  parameter int unsigned CLK_FREQ           = 50000000,
  parameter int unsigned DEFAULT_TIMEOUT_MS = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] in_data,
  input  logic [3:0]  in_ctrl,
  input  logic        in_wr,
  input  logic        any_wr,
  output logic [23:0] out_data,
  output logic [3:0]  out_ctrl,
  output logic        out_wr,
  input  logic        out_wr_rdy,
  output logic        safe_stop
);

  localparam int unsigned DIV_RAW = CLK_FREQ / 1000;
  localparam int unsigned DIV     = (DIV_RAW > 1) ? DIV_RAW : 1;
  localparam int unsigned PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CW      = 16;
  localparam logic [PW-1:0] PRESC_MAX   = PW'(DIV - 1);
  localparam logic [CW-1:0] DEF_TIMEOUT = CW'(DEFAULT_TIMEOUT_MS);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_TRIPPED  = 2'd2
  } state_t;

  localparam state_t RESET_STATE = (DEFAULT_TIMEOUT_MS == 0) ? ST_DISABLED : ST_ARMED;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [CW-1:0] r_timeout, w_timeout_nxt;
  logic [CW-1:0] r_trip_count, w_trip_count_nxt;
  logic          r_pend_trip, w_pend_trip_nxt;
  logic          r_pend_status, w_pend_status_nxt;
  logic          r_safe_stop;
  logic [23:0]   r_out_data, w_out_data_nxt;
  logic [3:0]    r_out_ctrl, w_out_ctrl_nxt;
  logic          r_out_wr;
  logic          w_ms_tick;
  logic          w_cmd_set, w_cmd_clr, w_cmd_qry;
  logic          w_trip, w_issue;
  logic [CW-1:0] w_new_to;
  logic          w_unused;

  assign w_ms_tick = (r_presc == PRESC_MAX);
  assign w_cmd_set = in_wr && (in_ctrl == 4'd0);
  assign w_cmd_clr = in_wr && (in_ctrl == 4'd1);
  assign w_cmd_qry = in_wr && (in_ctrl == 4'd2);
  assign w_new_to  = in_data[15:0];
  assign w_unused  = ^in_data[23:16];

  assign out_data  = r_out_data;
  assign out_ctrl  = r_out_ctrl;
  assign out_wr    = r_out_wr;
  assign safe_stop = r_safe_stop;

  // Next-state, counter, trip and readback-issue logic
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_timeout_nxt     = r_timeout;
    w_trip            = 1'b0;
    w_presc_nxt       = w_ms_tick ? '0 : r_presc + PW'(1);
    w_out_data_nxt    = r_out_data;
    w_out_ctrl_nxt    = r_out_ctrl;

    case (r_state)
      ST_DISABLED: begin
        w_cnt_nxt = '0;
        if (w_cmd_set) begin
          w_timeout_nxt = w_new_to;
          if (w_new_to != '0) w_state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (w_cmd_set) begin
          w_timeout_nxt = w_new_to;
          w_cnt_nxt     = '0;
          if (w_new_to == '0) w_state_nxt = ST_DISABLED;
        end else if (any_wr) begin
          // Kick wins over a coincident tick
          w_cnt_nxt = '0;
        end else if (w_ms_tick) begin
          if (r_cnt == r_timeout - CW'(1)) begin
            w_trip      = 1'b1;
            w_state_nxt = ST_TRIPPED;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      ST_TRIPPED: begin
        if (w_cmd_set) begin
          w_timeout_nxt = w_new_to;
          w_cnt_nxt     = '0;
          if (w_new_to == '0) w_state_nxt = ST_DISABLED;
        end else if (w_cmd_clr) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (r_timeout == '0) ? ST_DISABLED : ST_ARMED;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_DISABLED;
      end
    endcase

    w_trip_count_nxt = (w_trip && (r_trip_count != 16'hFFFF)) ? r_trip_count + CW'(1)
                                                              : r_trip_count;

    // One issue at most every other cycle; trip message has priority
    w_issue = (r_pend_trip || r_pend_status) && out_wr_rdy && !r_out_wr;
    if (w_issue) begin
      if (r_pend_trip) begin
        w_out_ctrl_nxt = 4'h1;
        w_out_data_nxt = {8'h00, r_trip_count};
      end else begin
        w_out_ctrl_nxt = 4'h2;
        w_out_data_nxt = {r_state, 6'b0, r_cnt};
      end
    end

    w_pend_trip_nxt   = (r_pend_trip && !w_issue) || w_trip;
    w_pend_status_nxt = (r_pend_status && !(w_issue && !r_pend_trip)) || w_cmd_qry;
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RESET_STATE;
      r_presc       <= '0;
      r_cnt         <= '0;
      r_timeout     <= DEF_TIMEOUT;
      r_trip_count  <= '0;
      r_pend_trip   <= 1'b0;
      r_pend_status <= 1'b0;
      r_safe_stop   <= 1'b0;
      r_out_data    <= '0;
      r_out_ctrl    <= '0;
      r_out_wr      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_presc       <= w_presc_nxt;
      r_cnt         <= w_cnt_nxt;
      r_timeout     <= w_timeout_nxt;
      r_trip_count  <= w_trip_count_nxt;
      r_pend_trip   <= w_pend_trip_nxt;
      r_pend_status <= w_pend_status_nxt;
      r_safe_stop   <= (w_state_nxt == ST_TRIPPED);
      r_out_data    <= w_out_data_nxt;
      r_out_ctrl    <= w_out_ctrl_nxt;
      r_out_wr      <= w_issue;
    end
  end

endmodule

// File: tb/tb_link_watchdog.sv
// Directed bench for link_watchdog with a 10-cycle millisecond prescaler.
module tb_link_watchdog;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] in_data;
  logic [3:0]  in_ctrl;
  logic        in_wr;
  logic        any_wr;
  logic [23:0] out_data;
  logic [3:0]  out_ctrl;
  logic        out_wr;
  logic        out_wr_rdy;
  logic        safe_stop;

  link_watchdog #(.CLK_FREQ(10000), .DEFAULT_TIMEOUT_MS(200)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
    .any_wr(any_wr), .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr),
    .out_wr_rdy(out_wr_rdy), .safe_stop(safe_stop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic [23:0] data;
    int          cyc;
  } msg_t;

  typedef struct {
    logic [15:0] timeout;
    int          dmin;
    int          dmax;
    logic [23:0] exp_data;
  } vec_t;

  msg_t q[$];
  msg_t m_cap;
  int   cyc = 0;
  int   b2b = 0;
  logic prev_wr = 1'b0;
  int   checks = 0;
  int   failures = 0;

  // Cycle stamp for captured messages
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every readback pulse and flag back-to-back issues
  always @(negedge clk) begin
    if (out_wr === 1'b1) begin
      m_cap.ctrl = out_ctrl;
      m_cap.data = out_data;
      m_cap.cyc  = cyc;
      q.push_back(m_cap);
      if (prev_wr) b2b++;
    end
    prev_wr = (out_wr === 1'b1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cmd(input logic [3:0] c, input logic [23:0] d);
    in_wr   = 1'b1;
    any_wr  = 1'b1;
    in_ctrl = c;
    in_data = d;
    step(1);
    in_wr   = 1'b0;
    any_wr  = 1'b0;
    in_ctrl = 4'd0;
    in_data = 24'd0;
  endtask

  task automatic wait_trip(input int maxc, output int d);
    d = -1;
    for (int n = 1; n <= maxc; n++) begin
      step(1);
      if (safe_stop === 1'b1) begin
        d = n;
        break;
      end
    end
  endtask

  vec_t tbl[5];
  int   d;
  int   hi;

  initial begin
    tbl[0] = '{timeout: 16'd5, dmin: 41, dmax: 50, exp_data: 24'h000001};
    tbl[1] = '{timeout: 16'd1, dmin: 1,  dmax: 10, exp_data: 24'h000002};
    tbl[2] = '{timeout: 16'd3, dmin: 21, dmax: 30, exp_data: 24'h000003};
    tbl[3] = '{timeout: 16'd2, dmin: 11, dmax: 20, exp_data: 24'h000004};
    tbl[4] = '{timeout: 16'd7, dmin: 61, dmax: 70, exp_data: 24'h000005};

    rst = 1'b1; in_data = '0; in_ctrl = '0; in_wr = 1'b0; any_wr = 1'b0; out_wr_rdy = 1'b1;
    step(3);
    chk("rst_safe_stop", 32'(safe_stop), 0);
    chk("rst_out_wr", 32'(out_wr), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_ctrl", 32'(out_ctrl), 0);
    rst = 1'b0;
    step(2);

    // Default state is ARMED with counter just kicked by the query write
    q.delete();
    cmd(4'd2, 24'd0);
    step(4);
    chk("query_default_cnt", 32'(q.size()), 1);
    if (q.size() > 0) begin
      chk("query_default_ctrl", 32'(q[0].ctrl), 32'h2);
      chk("query_default_data", 32'(q[0].data), 32'h400000);
    end

    // Table: timeout, trip latency window from CLEAR, trip message payload
    for (int i = 0; i < 5; i++) begin
      cmd(4'd0, 24'(tbl[i].timeout));
      if (i > 0) chk("set_keeps_trip", 32'(safe_stop), 1);
      cmd(4'd1, 24'd0);
      chk("clear_release", 32'(safe_stop), 0);
      q.delete();
      wait_trip(200, d);
      chk_range("trip_latency", d, tbl[i].dmin, tbl[i].dmax);
      step(4);
      chk("trip_msg_cnt", 32'(q.size()), 1);
      if (q.size() > 0) begin
        chk("trip_msg_ctrl", 32'(q[0].ctrl), 32'h1);
        chk("trip_msg_data", 32'(q[0].data), 32'(tbl[i].exp_data));
      end
    end

    // Regular kicks keep the link alive
    cmd(4'd0, 24'd5);
    cmd(4'd1, 24'd0);
    q.delete();
    hi = 0;
    for (int k = 0; k < 33; k++) begin
      any_wr = 1'b1;
      step(1);
      any_wr = 1'b0;
      if (safe_stop !== 1'b0) hi++;
      for (int j = 0; j < 29; j++) begin
        step(1);
        if (safe_stop !== 1'b0) hi++;
      end
    end
    chk("kick_no_trip", 32'(hi), 0);
    chk("kick_no_msg", 32'(q.size()), 0);
    wait_trip(100, d);
    chk_range("stop_kick_trip", 29 + d, 41, 50);
    step(4);
    chk("kick_trip_msg_cnt", 32'(q.size()), 1);
    if (q.size() > 0) chk("kick_trip_msg_data", 32'(q[0].data), 32'h000006);

    // Kicks never clear a trip
    for (int k = 0; k < 3; k++) begin
      any_wr = 1'b1;
      step(1);
      any_wr = 1'b0;
      step(2);
    end
    chk("kick_keeps_trip", 32'(safe_stop), 1);

    // Backpressure: trip and query both pending, released in priority order
    out_wr_rdy = 1'b0;
    cmd(4'd1, 24'd0);
    chk("clear_release2", 32'(safe_stop), 0);
    q.delete();
    wait_trip(100, d);
    chk_range("bp_trip_latency", d, 41, 50);
    cmd(4'd2, 24'd0);
    cmd(4'd2, 24'd0);
    step(5);
    chk("bp_held", 32'(q.size()), 0);
    out_wr_rdy = 1'b1;
    step(8);
    chk("bp_msg_cnt", 32'(q.size()), 2);
    if (q.size() == 2) begin
      chk("bp_first_ctrl", 32'(q[0].ctrl), 32'h1);
      chk("bp_first_data", 32'(q[0].data), 32'h000007);
      chk("bp_second_ctrl", 32'(q[1].ctrl), 32'h2);
      chk("bp_second_data", 32'(q[1].data), 32'h800004);
      chk("bp_gap", 32'((q[1].cyc - q[0].cyc) >= 2), 1);
    end

    // Zero timeout while tripped disables the watchdog
    cmd(4'd0, 24'd0);
    chk("disable_release", 32'(safe_stop), 0);
    q.delete();
    cmd(4'd2, 24'd0);
    step(4);
    chk("disabled_msg_cnt", 32'(q.size()), 1);
    if (q.size() > 0) begin
      chk("disabled_ctrl", 32'(q[0].ctrl), 32'h2);
      chk("disabled_data", 32'(q[0].data), 32'h000000);
    end
    q.delete();
    hi = 0;
    for (int k = 0; k < 2000; k++) begin
      step(1);
      if (safe_stop !== 1'b0) hi++;
    end
    chk("disabled_no_trip", 32'(hi), 0);
    chk("disabled_no_msg", 32'(q.size()), 0);

    // Reset mid-count with a status request pending
    cmd(4'd0, 24'd5);
    step(23);
    out_wr_rdy = 1'b0;
    cmd(4'd2, 24'd0);
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mid_rst_safe_stop", 32'(safe_stop), 0);
    chk("mid_rst_out_wr", 32'(out_wr), 0);
    chk("mid_rst_out_ctrl", 32'(out_ctrl), 0);
    chk("mid_rst_out_data", 32'(out_data), 0);
    q.delete();
    out_wr_rdy = 1'b1;
    wait_trip(2100, d);
    chk_range("default_timeout_latency", d, 1991, 2000);
    step(4);
    chk("post_rst_msg_cnt", 32'(q.size()), 1);
    if (q.size() > 0) begin
      chk("post_rst_ctrl", 32'(q[0].ctrl), 32'h1);
      chk("post_rst_data", 32'(q[0].data), 32'h000001);
    end

    chk("no_back_to_back", 32'(b2b), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/link_watchdog.md
Name: link_watchdog

Overview:
- Command-link watchdog fed by the Jetson SPI write bus and fed back into the readback arbiter as one more output channel.
- Monitors Jetson -> core write activity. If the host stops talking for longer than a programmable timeout, it asserts `safe_stop`, which gates the motor and amp enables at top level.
- Reports trips and status through the standard `out_data`/`out_ctrl`/`out_wr`/`out_wr_rdy` readback handshake.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz. Sets the millisecond prescaler `DIV = CLK_FREQ/1000`.
- DEFAULT_TIMEOUT_MS, 200, timeout loaded at reset, in ms. 0 means disabled.

Ports:
- `clk` input 1: system clock; all logic is in this single domain.
- `rst` input 1: synchronous, active-high reset.
- `in_data` input 24: command payload.
- `in_ctrl` input 4: command opcode.
- `in_wr` input 1: one-cycle strobe for a write addressed to this block.
- `any_wr` input 1: one-cycle strobe for any Jetson write, any address. This is the activity kick.
- `out_data` output 24: readback payload.
- `out_ctrl` output 4: readback type.
- `out_wr` output 1: one-cycle readback request.
- `out_wr_rdy` input 1: arbiter can accept (this is ~busy).
- `safe_stop` output 1: high while tripped.

Behaviour:
- Reset values:
  - `out_data` = 0, `out_ctrl` = 0, `out_wr` = 0, `safe_stop` = 0.
  - timeout = DEFAULT_TIMEOUT_MS; ms counter = 0; prescaler = 0; trip_count = 0; pending flags = 0.
  - state = ARMED, or DISABLED if DEFAULT_TIMEOUT_MS == 0.
- Prescaler: counts 0..DIV-1 and raises `ms_tick` for one cycle on wrap. It is free-running and not cleared by kicks. This gives a timeout granularity of -1 ms/+0.
- Commands are decoded only when `in_wr` = 1.
  - ctrl 0 (SET_TIMEOUT): timeout <= `in_data[15:0]`; ms counter <= 0. A value of 0 moves to DISABLED (and clears `safe_stop`). A non-zero value from DISABLED moves to ARMED. In TRIPPED it updates the timeout and the state stays TRIPPED.
  - ctrl 1 (CLEAR): TRIPPED -> ARMED (or DISABLED if timeout == 0); `safe_stop` <= 0; ms counter <= 0. No effect in other states.
  - ctrl 2 (QUERY): sets `pend_status`.
  - ctrl 3..15: ignored.
- Kick: `any_wr` clears the ms counter in ARMED only. A kick never clears TRIPPED; only CLEAR does. A CLEAR write also asserts `any_wr`, which is harmless.
- States:
  - DISABLED: counter held at 0; `safe_stop` = 0.
  - ARMED: on `ms_tick` with no kick in the same cycle, counter++. When the counter increment would reach timeout (counter == timeout-1 at tick), go to TRIPPED: `safe_stop` <= 1 (registered, next cycle), trip_count++ (16-bit, saturates at 0xFFFF), set `pend_trip`.
  - TRIPPED: counter frozen; `safe_stop` = 1.
- Simultaneous events in one cycle:
  - Kick and tick together: the kick wins; counter = 0.
  - A SET_TIMEOUT or CLEAR in the same cycle as a trip condition: the command wins and no trip occurs.
- Readback (two sticky pending flags):
  - A message is issued when a flag is set and `out_wr_rdy` = 1. In that cycle: `out_wr` = 1 for exactly one cycle; `out_data`/`out_ctrl` are registered and held stable until the next issue; the flag is cleared.
  - `pend_trip` has priority over `pend_status`.
  - At most one issue per two cycles: after issuing, `out_wr` is 0 for at least one cycle.
  - Trip message: `out_ctrl` = 4'h1, `out_data` = {8'h00, trip_count[15:0]}, with the post-increment count.
  - Status message: `out_ctrl` = 4'h2, `out_data` = {state[1:0], 6'b0, ms_counter[15:0]}. Encoding: DISABLED = 0, ARMED = 1, TRIPPED = 2.
  - A re-request while a flag is already pending merges into that one message.
  - Reset clears pending flags immediately, including mid-wait.
- Width rules: timeout and counter are 16 bits unsigned, so the maximum timeout is 65535 ms. The counter never exceeds timeout-1.

Test Plan:
- Setup for all scenarios: CLK_FREQ = 10000 (DIV = 10); reset; SET_TIMEOUT 5; no kicks. Expect `safe_stop` rising 5 ticks (50 clk ±10) after the write, then one `out_wr` with `out_ctrl` = 1, `out_data` = 0x000001.
- Kick every 30 clk for 1000 clk -> `safe_stop` stays 0 and no `out_wr`. Then stop kicking -> trip within 50 clk.
- While tripped: `any_wr` pulses -> `safe_stop` remains 1. CLEAR -> `safe_stop` = 0 the next cycle. Trip again -> trip message `out_data` = 0x000002.
- Hold `out_wr_rdy` = 0 during a trip, then issue QUERY. Release rdy -> trip message first, status message (`out_ctrl` = 2, `out_data[23:22]` = 2) no earlier than 2 cycles later, exactly one each.
- SET_TIMEOUT 0 while tripped -> `safe_stop` = 0, state DISABLED. QUERY -> `out_data` = 0x000000; no trips for 2000 clk.
- Assert `rst` mid-count with `pend_status` set -> all outputs 0 the next cycle, no stale `out_wr`, timeout back to 200.
